// File: rtl/fa_4bits_cla_pkg.sv
// Shared width and word type for the 4-bit carry-lookahead adder slice.
// Optional signed-overflow output is enabled with FA_4BITS_CLA_OVF_EN.
package fa_4bits_cla_pkg;

  localparam int FA_W = 4;

  typedef logic [FA_W-1:0] fa_word_t;

endpackage

// File: rtl/fa_4bits_cla_cla_logic_4.sv
// Combinational 4-bit carry-lookahead core: per-bit p/g, flat carry equations, group p/g and sum.
// With FA_4BITS_CLA_OVF_EN the signed overflow (c4 ^ c3) is also produced.
module cla_logic_4
  import fa_4bits_cla_pkg::*;
(
  input  fa_word_t a,
  input  fa_word_t b,
  input  logic     cin,
  output fa_word_t sum,
  output logic     carry,
  output logic     grp_p,
  output logic     grp_g
`ifdef FA_4BITS_CLA_OVF_EN
  ,
  output logic     ovf
`endif
);

  fa_word_t p;
  fa_word_t g;
  logic     c1;
  logic     c2;
  logic     c3;
  logic     c4;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat sum of products of p/g and cin; no carry feeds another.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign c4    = grp_g | (grp_p & cin);

  assign sum   = p ^ {c3, c2, c1, cin};
  assign carry = c4;

`ifdef FA_4BITS_CLA_OVF_EN
  assign ovf = c4 ^ c3;
`else
  logic unused_c3;
  assign unused_c3 = c3;
`endif

endmodule

// File: rtl/fa_4bits_cla.sv
// Registered 4-bit carry-lookahead adder: one-cycle latency, one operand per cycle.
// Define FA_4BITS_CLA_OVF_EN to add the registered signed-overflow output ovf.
module fa_4bits_cla
  import fa_4bits_cla_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       out_valid,
  output logic [3:0] sum,
  output logic       carry,
  output logic       grp_p,
  output logic       grp_g
`ifdef FA_4BITS_CLA_OVF_EN
  ,
  output logic       ovf
`endif
);

  // Handshake: in_valid qualifies a/b/cin at the clock edge; there is no ready, so an
  // operand is accepted every valid cycle. out_valid is high for exactly the cycle after
  // each accepted operand; result outputs keep their last value while out_valid is low.

  fa_word_t cla_sum;
  logic     cla_carry;
  logic     cla_grp_p;
  logic     cla_grp_g;

  logic     out_valid_d, out_valid_q;
  fa_word_t sum_d, sum_q;
  logic     carry_d, carry_q;
  logic     grp_p_d, grp_p_q;
  logic     grp_g_d, grp_g_q;

`ifdef FA_4BITS_CLA_OVF_EN
  logic     cla_ovf;
  logic     ovf_d, ovf_q;
`endif

  cla_logic_4 u_cla (
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (cla_sum),
    .carry (cla_carry),
    .grp_p (cla_grp_p),
    .grp_g (cla_grp_g)
`ifdef FA_4BITS_CLA_OVF_EN
    ,
    .ovf   (cla_ovf)
`endif
  );

  always_comb begin
    out_valid_d = in_valid;
    sum_d       = sum_q;
    carry_d     = carry_q;
    grp_p_d     = grp_p_q;
    grp_g_d     = grp_g_q;
    if (in_valid) begin
      sum_d   = cla_sum;
      carry_d = cla_carry;
      grp_p_d = cla_grp_p;
      grp_g_d = cla_grp_g;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      grp_p_q     <= 1'b0;
      grp_g_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      grp_p_q     <= grp_p_d;
      grp_g_q     <= grp_g_d;
    end
  end

`ifdef FA_4BITS_CLA_OVF_EN
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = cla_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign grp_p     = grp_p_q;
  assign grp_g     = grp_g_q;

endmodule

// File: tb/tb_fa_4bits_cla.sv
// Scoreboard bench for fa_4bits_cla: driver pushes arithmetic-model results, a negedge
// monitor pops and compares them, plus directed boundary, hold and reset checks.
module tb_fa_4bits_cla;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       out_valid;
  logic [3:0] sum;
  logic       carry;
  logic       grp_p;
  logic       grp_g;
  logic       dut_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Packed result layout: {ovf, grp_g, grp_p, carry, sum[3:0]}
  logic [7:0] exp_q[$];
  int         cyc_q[$];
  logic [7:0] mask;

  fa_4bits_cla dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .carry     (carry),
    .grp_p     (grp_p),
    .grp_g     (grp_g)
`ifdef FA_4BITS_CLA_OVF_EN
    ,
    .ovf       (dut_ovf)
`endif
  );

`ifdef FA_4BITS_CLA_OVF_EN
  assign mask = 8'hFF;
`else
  assign dut_ovf = 1'b0;
  assign mask = 8'h7F;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [7:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
    int total;
    int sa;
    int sb;
    int stot;
    logic [7:0] r;
    total = int'(ma) + int'(mb) + int'(mc);
    sa = (ma >= 8) ? int'(ma) - 16 : int'(ma);
    sb = (mb >= 8) ? int'(mb) - 16 : int'(mb);
    stot = sa + sb + int'(mc);
    r[3:0] = 4'(total % 16);
    r[4]   = (total >= 16);
    r[5]   = ((ma ^ mb) == 4'hF);
    r[6]   = ((int'(ma) + int'(mb)) >= 16);
    r[7]   = (stot > 7) || (stot < -8);
    return r;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    cin = ic;
    exp_q.push_back(model(ia, ib, ic));
    cyc_q.push_back(cyc + 1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    cin = 1'($urandom_range(0, 1));
  endtask

  // Issue one operand, drop in_valid, then check the result fields against constants.
  task automatic directed(input string name, input logic [3:0] ia, input logic [3:0] ib,
                          input logic ic, input logic [3:0] es, input logic ec);
    issue(ia, ib, ic);
    idle();
    @(negedge clk);
    chk({name, "_valid"}, 8'(out_valid), 8'd1);
    chk({name, "_sum"}, 8'(sum), 8'(es));
    chk({name, "_carry"}, 8'(carry), 8'(ec));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got out_valid=1 sum=%h required no output", sum);
        end else begin
          logic [7:0] e;
          int ec;
          e = exp_q.pop_front();
          ec = cyc_q.pop_front();
          chk("result", {dut_ovf, grp_g, grp_p, carry, sum} & mask, e & mask);
          n_checks++;
          if (ec != cyc) begin
            n_errors++;
            $display("FAIL latency: got result at cycle %0d required cycle %0d", cyc, ec);
          end
        end
      end else if (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_out: got out_valid=0 at cycle %0d required result due cycle %0d",
                 cyc, cyc_q[0]);
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] held;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = 4'h0;
    b = 4'h0;
    cin = 1'b0;
    #12;
    chk("reset_out_valid", 8'(out_valid), 8'd0);
    chk("reset_outputs", {dut_ovf, grp_g, grp_p, carry, sum}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors and boundaries
    directed("f_plus_1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
    chk("f_plus_1_grp_p", 8'(grp_p), 8'd0);
    chk("f_plus_1_grp_g", 8'(grp_g), 8'd1);
    directed("prop_chain", 4'h5, 4'hA, 1'b1, 4'h0, 1'b1);
    chk("prop_chain_grp_p", 8'(grp_p), 8'd1);
    chk("prop_chain_grp_g", 8'(grp_g), 8'd0);
    directed("f_0_1", 4'hF, 4'h0, 1'b1, 4'h0, 1'b1);
    directed("f_f_1", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
    directed("zero", 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
`ifdef FA_4BITS_CLA_OVF_EN
    directed("ovf_pos", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0);
    chk("ovf_pos_ovf", 8'(dut_ovf), 8'd1);
    directed("ovf_neg", 4'h8, 4'hF, 1'b0, 4'h7, 1'b1);
    chk("ovf_neg_ovf", 8'(dut_ovf), 8'd1);
`endif

    // Hold: one valid, then three idle cycles
    held = model(4'h9, 4'h8, 1'b1);
    issue(4'h9, 4'h8, 1'b1);
    idle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk);
      chk("hold_out_valid", 8'(out_valid), 8'd0);
      chk("hold_sum_carry", {3'b000, carry, sum}, {3'b000, held[4:0]});
    end

    // Exhaustive back-to-back
    for (int i = 0; i < 512; i++) begin
      issue(4'(i & 15), 4'((i >> 4) & 15), 1'((i >> 8) & 1));
    end
    idle();

    // Randomized traffic with idle gaps
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle();
      else issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-stream, between clock edges
    issue(4'h3, 4'h4, 1'b0);
    issue(4'hC, 4'h7, 1'b1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    #1;
    chk("async_rst_out_valid", 8'(out_valid), 8'd0);
    chk("async_rst_outputs", {dut_ovf, grp_g, grp_p, carry, sum}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("rst_hold_outputs", {dut_ovf, grp_g, grp_p, out_valid, carry, sum}, 8'h00);
    rst_n = 1'b1;
    directed("after_rst", 4'hB, 4'h6, 1'b1, 4'h2, 1'b1);

    repeat (3) idle();
    @(negedge clk);
    chk("drain_queue_empty", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
